coef_reg_bank: RTL and testbench
================================

COEF_REG_BANK -- requirements
Module: coef_reg_bank

Interface
REQ-001 SHALL have parameter DW, default 16, coefficient/data width; multiple of 8, 8..32.
REQ-002 SHALL have parameter NREG, default 5, coefficients per channel, 1..16.
REQ-003 SHALL have parameter NCH, default 2, channel count, 1..8; AW = clog2(NCH*NREG+1).
REQ-004 SHALL have port clk_i, input, 1, sole clock, rising edge.
REQ-005 SHALL have port rst_i, input, 1, reset, asynchronous, active-high.
REQ-006 SHALL have port cyc_i, input, 1, bus cycle valid.
REQ-007 SHALL have port stb_i, input, 1, transfer strobe.
REQ-008 SHALL have port we_i, input, 1, 1 = write, 0 = read.
REQ-009 SHALL have port adr_i, input, AW, word address.
REQ-010 SHALL have port sel_i, input, DW/8, byte enables for writes.
REQ-011 SHALL have port dat_i, input, DW, write data.
REQ-012 SHALL have port dat_o, output, DW, registered read data.
REQ-013 SHALL have port ack_o, output, 1, registered normal termination.
REQ-014 SHALL have port err_o, output, 1, registered error termination.
REQ-015 SHALL have port sample_tick_i, input, 1, datapath sample boundary pulse.
REQ-016 SHALL have port coef_o, output, NCH*NREG*DW, active coefficients, index ch*NREG+r, LSB-first.
REQ-017 SHALL have port commit_pending_o, output, 1, commit armed, not yet applied.
REQ-018 SHALL have port coef_upd_o, output, 1, one-cycle pulse when active set is reloaded.

Function
REQ-019 Address map SHALL be: 0..NCH*NREG-1 shadow coefficient (ch = adr/NREG, r = adr%NREG); NCH*NREG control; above that invalid.
REQ-020 Bus FSM SHALL have states IDLE and RESP; IDLE->RESP when cyc_i&stb_i; RESP->IDLE unconditionally, so ack_o/err_o are single-cycle pulses one cycle after request.
REQ-021 Exactly one of ack_o/err_o SHALL assert per accepted request: ack_o for valid address, err_o for invalid; both never high together.
REQ-022 A write SHALL update only the shadow bytes enabled by sel_i, at the IDLE->RESP edge; sel_i = 0 writes nothing but still acks.
REQ-023 A read SHALL load dat_o at the IDLE->RESP edge with the shadow value (not active); control read returns bit1 = commit_pending_o, other bits 0; err_o cycle and non-read cycles leave dat_o at 0.
REQ-024 Writes to invalid addresses SHALL change no state.
REQ-025 Control write with dat_i[0]=1 and sel_i[0]=1 SHALL set commit pending (CLEAN->PENDING); dat_i[0]=0 SHALL have no effect; other bits ignored.
REQ-026 In PENDING on sample_tick_i, all active registers SHALL load all shadow registers in one edge, pending SHALL clear, coef_upd_o SHALL pulse next cycle.
REQ-027 sample_tick_i in CLEAN SHALL change nothing.
REQ-028 Commit request and sample_tick_i in the same cycle: pending sets, copy waits for the next tick.
REQ-029 Shadow write and committing tick in the same cycle: active SHALL receive pre-write shadow value; shadow holds new value.
REQ-030 Repeated commit requests while PENDING SHALL be idempotent.
REQ-031 coef_o SHALL change only on a committing tick or reset, never on a bus write.

Reset
REQ-032 rst_i SHALL asynchronously force: bus FSM IDLE, ack_o=0, err_o=0, dat_o=0, pending CLEAN, commit_pending_o=0, coef_upd_o=0.
REQ-033 rst_i SHALL load shadow and active of every channel with package reset table (DW=16, NREG=5: 00FF, 001F, 007F, 0003, 00FF; r beyond table = 0; truncated/zero-extended to DW).
REQ-034 Reset mid-transfer SHALL abort it silently; master retries.

Structure
REQ-035 Package coef_bank_pkg SHALL hold default DW/NREG/NCH, reset-value table, control bit positions (COMMIT=0, PENDING=1) and the bus FSM state enum.
REQ-036 One sub-module coef_chan_regs SHALL hold one channel's NREG shadow+active registers with byte-lane write and commit load; top instantiates NCH copies.

Verification
REQ-037 Reset, read adr 0..4 (ch0) -> dat_o 00FF,001F,007F,0003,00FF, each ack_o one cycle after stb.
REQ-038 Write adr 6 = 1234 sel=11 -> read back 1234; coef_o ch1 r1 stays 001F until commit.
REQ-039 Write adr 2 = ABCD sel=01 -> shadow 00CD; write sel=10 -> ABCD.
REQ-040 Write ctrl=1, read ctrl -> 0002; tick -> coef_o updates, coef_upd_o one pulse, ctrl reads 0000.
REQ-041 Access adr 11 (defaults) -> err_o one cycle, ack_o 0, no state change.
REQ-042 Write ctrl=1 concurrent with tick -> no update; next tick updates; rst_i mid-RESP -> ack_o drops immediately.

Source files
------------

// File: rtl/coef_bank_pkg.sv
// Shared constants for the coefficient register bank: default geometry,
// per-register reset values, control-word bit positions and FSM encodings.
package coef_bank_pkg;

    // Default geometry of one bank instance.
    localparam int DEF_DW   = 16;
    localparam int DEF_NREG = 5;
    localparam int DEF_NCH  = 2;

    // Bit positions inside the control word.
    localparam int CTRL_COMMIT  = 0;
    localparam int CTRL_PENDING = 1;

    // Number of entries in the reset value table; registers past it reset to 0.
    localparam int RST_TABLE_LEN = 5;

    // Bus handshake FSM: one request is accepted in IDLE, answered in RESP.
    typedef enum logic {
        BUS_IDLE = 1'b0,
        BUS_RESP = 1'b1
    } bus_state_e;

    // Commit tracker: PENDING means shadow -> active copy is armed.
    typedef enum logic {
        CMT_CLEAN   = 1'b0,
        CMT_PENDING = 1'b1
    } commit_state_e;

    // Reset value of coefficient r (same for every channel), 32 bits wide so
    // the caller can truncate to its own data width.
    function automatic logic [31:0] coef_reset_val(input int r);
        logic [31:0] v;
        case (r)
            0:       v = 32'h0000_00FF;
            1:       v = 32'h0000_001F;
            2:       v = 32'h0000_007F;
            3:       v = 32'h0000_0003;
            4:       v = 32'h0000_00FF;
            default: v = 32'h0000_0000;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/coef_chan_regs.sv
// One channel of coefficients: NREG shadow registers written byte-wise from
// the bus, and NREG active registers that load all shadows at once on commit.
module coef_chan_regs
    import coef_bank_pkg::*;
#(
    parameter  int DW   = DEF_DW,
    parameter  int NREG = DEF_NREG,
    localparam int IW   = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 wr_en_i,
    input  logic [IW-1:0]        wr_idx_i,
    input  logic [DW/8-1:0]      sel_i,
    input  logic [DW-1:0]        dat_i,
    input  logic                 commit_i,
    output logic [NREG*DW-1:0]   shadow_o,
    output logic [NREG*DW-1:0]   active_o
);

    localparam int SW = DW / 8;

    logic [DW-1:0] shadow_q [NREG];
    logic [DW-1:0] shadow_d [NREG];
    logic [DW-1:0] active_q [NREG];
    logic [DW-1:0] active_d [NREG];
    logic [DW-1:0] rst_val  [NREG];

    // Reset constants and flattened views of both register sets.
    for (genvar r = 0; r < NREG; r++) begin : g_reg
        localparam logic [31:0] RV = coef_reset_val(r);
        assign rst_val[r]             = RV[DW-1:0];
        assign shadow_o[r*DW +: DW]   = shadow_q[r];
        assign active_o[r*DW +: DW]   = active_q[r];
    end

    // Shadow next value: only the enabled byte lanes of the addressed register move.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            shadow_d[r] = shadow_q[r];
        end
        if (wr_en_i) begin
            for (int r = 0; r < NREG; r++) begin
                if (wr_idx_i == IW'(r)) begin
                    for (int b = 0; b < SW; b++) begin
                        if (sel_i[b]) begin
                            shadow_d[r][b*8 +: 8] = dat_i[b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    // Active next value: a commit copies the pre-write shadow contents, so a
    // bus write landing on the same edge only affects the shadow.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            active_d[r] = commit_i ? shadow_q[r] : active_q[r];
        end
    end

    // Register storage; both sets come out of reset with the table values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int r = 0; r < NREG; r++) begin
                shadow_q[r] <= rst_val[r];
                active_q[r] <= rst_val[r];
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                shadow_q[r] <= shadow_d[r];
                active_q[r] <= active_d[r];
            end
        end
    end

endmodule

// File: rtl/coef_reg_bank.sv
// Coefficient register bank with a single-cycle bus slave.
// Handshake: a request is cyc_i & stb_i while the slave is IDLE; it is taken
// on that clock edge and answered on the next cycle by exactly one of
// ack_o (valid address) or err_o (invalid address), each high for one cycle.
// Requests seen while the slave is answering are not taken.
// Coefficients live in shadow registers written by the bus; the datapath sees
// the active copy, reloaded from all shadows at once on a sample_tick_i after
// a commit has been armed through the control word.
module coef_reg_bank
    import coef_bank_pkg::*;
#(
    parameter  int DW   = DEF_DW,
    parameter  int NREG = DEF_NREG,
    parameter  int NCH  = DEF_NCH,
    localparam int AW   = $clog2(NCH*NREG+1)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    cyc_i,
    input  logic                    stb_i,
    input  logic                    we_i,
    input  logic [AW-1:0]           adr_i,
    input  logic [DW/8-1:0]         sel_i,
    input  logic [DW-1:0]           dat_i,
    output logic [DW-1:0]           dat_o,
    output logic                    ack_o,
    output logic                    err_o,
    input  logic                    sample_tick_i,
    output logic [NCH*NREG*DW-1:0]  coef_o,
    output logic                    commit_pending_o,
    output logic                    coef_upd_o,
    output logic                    bus_state_o
);

    localparam int NWORD = NCH * NREG;
    localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int IW    = (NREG > 1) ? $clog2(NREG) : 1;

    bus_state_e     state_q, state_d;
    commit_state_e  cmt_q, cmt_d;
    logic           ack_q, ack_d;
    logic           err_q, err_d;
    logic [DW-1:0]  dat_q, dat_d;
    logic           upd_q, upd_d;

    logic [31:0]        adr_ext;
    logic               is_coef;
    logic               is_ctrl;
    logic [CW-1:0]      adr_ch;
    logic [IW-1:0]      adr_reg;
    logic               req;
    logic               commit_req;
    logic               commit_tick;
    logic [DW-1:0]      rd_word;
    logic [DW-1:0]      ctrl_word;
    logic [NWORD*DW-1:0] shadow_all;
    logic [NWORD*DW-1:0] active_all;

    // Address decode: coefficient words first, then the control word.
    always_comb begin
        adr_ext = {{(32-AW){1'b0}}, adr_i};
        is_coef = (adr_ext < 32'(NWORD));
        is_ctrl = (adr_ext == 32'(NWORD));
        adr_ch  = CW'(adr_ext / 32'(NREG));
        adr_reg = IW'(adr_ext % 32'(NREG));
    end

    assign req = cyc_i & stb_i & (state_q == BUS_IDLE);

    // One register channel per instance; writes only reach the decoded channel.
    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic ch_wr_en;
        assign ch_wr_en = req & we_i & is_coef & (adr_ch == CW'(c));

        coef_chan_regs #(
            .DW   (DW),
            .NREG (NREG)
        ) u_chan (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .wr_en_i  (ch_wr_en),
            .wr_idx_i (adr_reg),
            .sel_i    (sel_i),
            .dat_i    (dat_i),
            .commit_i (commit_tick),
            .shadow_o (shadow_all[c*NREG*DW +: NREG*DW]),
            .active_o (active_all[c*NREG*DW +: NREG*DW])
        );
    end

    // Read mux over the shadow words; reads never observe the active copy.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NWORD; i++) begin
            if (adr_ext == 32'(i)) begin
                rd_word = shadow_all[i*DW +: DW];
            end
        end
    end

    // Control word as seen by a read: only the pending flag is reported.
    always_comb begin
        ctrl_word               = '0;
        ctrl_word[CTRL_PENDING] = (cmt_q == CMT_PENDING);
    end

    // Bus FSM: accept in IDLE, answer for exactly one cycle in RESP.
    always_comb begin
        state_d    = state_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        dat_d      = '0;
        commit_req = 1'b0;
        case (state_q)
            BUS_IDLE: begin
                if (cyc_i && stb_i) begin
                    state_d = BUS_RESP;
                    if (is_coef || is_ctrl) begin
                        ack_d = 1'b1;
                        if (!we_i) begin
                            dat_d = is_coef ? rd_word : ctrl_word;
                        end else if (is_ctrl && sel_i[CTRL_COMMIT] && dat_i[CTRL_COMMIT]) begin
                            commit_req = 1'b1;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            BUS_RESP: begin
                state_d = BUS_IDLE;
            end
            default: begin
                state_d = BUS_IDLE;
            end
        endcase
    end

    // Commit tracker: a tick only copies once a commit was armed beforehand,
    // so a request on the same cycle as a tick waits for the following tick.
    always_comb begin
        cmt_d       = cmt_q;
        commit_tick = 1'b0;
        case (cmt_q)
            CMT_CLEAN: begin
                if (commit_req) begin
                    cmt_d = CMT_PENDING;
                end
            end
            CMT_PENDING: begin
                if (sample_tick_i) begin
                    commit_tick = 1'b1;
                    cmt_d       = CMT_CLEAN;
                end
            end
            default: begin
                cmt_d = CMT_CLEAN;
            end
        endcase
        upd_d = commit_tick;
    end

    // State and registered outputs; reset aborts any response in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= BUS_IDLE;
            cmt_q   <= CMT_CLEAN;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= '0;
            upd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cmt_q   <= cmt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dat_q   <= dat_d;
            upd_q   <= upd_d;
        end
    end

    assign dat_o            = dat_q;
    assign ack_o            = ack_q;
    assign err_o            = err_q;
    assign coef_upd_o       = upd_q;
    assign commit_pending_o = (cmt_q == CMT_PENDING);
    assign coef_o           = active_all;
    assign bus_state_o      = state_q;

endmodule

// File: tb/tb_coef_reg_bank.sv
// Bench for coef_reg_bank at default geometry (DW=16, NREG=5, NCH=2).
module tb_coef_reg_bank;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         cyc_i = 1'b0;
    logic         stb_i = 1'b0;
    logic         we_i  = 1'b0;
    logic [3:0]   adr_i = '0;
    logic [1:0]   sel_i = '0;
    logic [15:0]  dat_i = '0;
    logic         sample_tick_i = 1'b0;
    logic [15:0]  dat_o;
    logic         ack_o;
    logic         err_o;
    logic [159:0] coef_o;
    logic         commit_pending_o;
    logic         coef_upd_o;
    logic         bus_state_o;

    coef_reg_bank dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .cyc_i            (cyc_i),
        .stb_i            (stb_i),
        .we_i             (we_i),
        .adr_i            (adr_i),
        .sel_i            (sel_i),
        .dat_i            (dat_i),
        .dat_o            (dat_o),
        .ack_o            (ack_o),
        .err_o            (err_o),
        .sample_tick_i    (sample_tick_i),
        .coef_o           (coef_o),
        .commit_pending_o (commit_pending_o),
        .coef_upd_o       (coef_upd_o),
        .bus_state_o      (bus_state_o)
    );

    // Clock.
    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;
    int upd_cnt  = 0;

    // Expected response: {err, dat}.
    logic [16:0] exp_q[$];

    logic [15:0] def_tab [5] = '{16'h00FF, 16'h001F, 16'h007F, 16'h0003, 16'h00FF};
    logic [15:0] exp_act [10];

    typedef struct {
        logic        we;
        logic [3:0]  adr;
        logic [1:0]  sel;
        logic [15:0] dat;
        logic        exp_err;
        logic [15:0] exp_dat;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [15:0] cw(input int i);
        return coef_o[i*16 +: 16];
    endfunction

    task automatic check_coef(input string nm);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("%s_coef%0d", nm, i), cw(i), exp_act[i]);
        end
    endtask

    task automatic reset_model();
        for (int i = 0; i < 10; i++) exp_act[i] = def_tab[i % 5];
    endtask

    task automatic add_vec(input logic we, input logic [3:0] adr, input logic [1:0] sel,
                           input logic [15:0] dat, input logic exp_err, input logic [15:0] exp_dat);
        vec_t v;
        v.we = we; v.adr = adr; v.sel = sel; v.dat = dat; v.exp_err = exp_err; v.exp_dat = exp_dat;
        vecs.push_back(v);
    endtask

    // Driver: one transfer, optionally with sample_tick_i in the request cycle.
    task automatic bus_xfer(input logic we, input logic [3:0] adr, input logic [1:0] sel,
                            input logic [15:0] dat, input logic exp_err, input logic [15:0] exp_dat,
                            input logic tick);
        @(negedge clk_i);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = adr; sel_i = sel; dat_i = dat;
        sample_tick_i = tick;
        exp_q.push_back({exp_err, exp_dat});
        @(negedge clk_i);
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; sample_tick_i = 1'b0;
        @(negedge clk_i);
        chk("resp_seen", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic tick_pulse();
        @(negedge clk_i);
        sample_tick_i = 1'b1;
        @(negedge clk_i);
        sample_tick_i = 1'b0;
    endtask

    // Scoreboard: every ack/err is matched against the oldest expectation.
    always @(negedge clk_i) begin
        logic [16:0] e;
        if (!rst_i) begin
            if (coef_upd_o) upd_cnt++;
            if (ack_o || err_o) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_resp", {30'd0, ack_o, err_o}, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_err", err_o, e[16]);
                    chk("resp_ack", ack_o, !e[16]);
                    chk("resp_dat", dat_o, e[15:0]);
                end
            end
        end
    end

    initial begin
        int a;
        int upd0;
        reset_model();

        // Reset state.
        repeat (3) @(negedge clk_i);
        chk("rst_ack", ack_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_dat", dat_o, 0);
        chk("rst_pending", commit_pending_o, 0);
        chk("rst_upd", coef_upd_o, 0);
        check_coef("rst");
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("idle_state", bus_state_o, 0);

        // Table: defaults, byte-lane writes, control word, invalid addresses.
        for (int i = 0; i < 5; i++) add_vec(0, 4'(i), 2'b00, 16'h0, 0, def_tab[i]);
        add_vec(0, 4'd5,  2'b00, 16'h0000, 0, 16'h00FF);
        add_vec(0, 4'd9,  2'b00, 16'h0000, 0, 16'h00FF);
        add_vec(1, 4'd6,  2'b11, 16'h1234, 0, 16'h0000);
        add_vec(0, 4'd6,  2'b00, 16'h0000, 0, 16'h1234);
        add_vec(1, 4'd2,  2'b01, 16'hABCD, 0, 16'h0000);
        add_vec(0, 4'd2,  2'b00, 16'h0000, 0, 16'h00CD);
        add_vec(1, 4'd2,  2'b10, 16'hABCD, 0, 16'h0000);
        add_vec(0, 4'd2,  2'b00, 16'h0000, 0, 16'hABCD);
        add_vec(1, 4'd3,  2'b00, 16'hFFFF, 0, 16'h0000);
        add_vec(0, 4'd3,  2'b00, 16'h0000, 0, 16'h0003);
        add_vec(0, 4'd10, 2'b00, 16'h0000, 0, 16'h0000);
        add_vec(0, 4'd11, 2'b00, 16'h0000, 1, 16'h0000);
        add_vec(1, 4'd11, 2'b11, 16'hFFFF, 1, 16'h0000);
        add_vec(0, 4'd15, 2'b00, 16'h0000, 1, 16'h0000);
        add_vec(0, 4'd0,  2'b00, 16'h0000, 0, 16'h00FF);
        add_vec(1, 4'd10, 2'b01, 16'h0000, 0, 16'h0000);
        add_vec(0, 4'd10, 2'b00, 16'h0000, 0, 16'h0000);
        add_vec(1, 4'd10, 2'b10, 16'hFFFF, 0, 16'h0000);
        add_vec(0, 4'd10, 2'b00, 16'h0000, 0, 16'h0000);
        add_vec(1, 4'd10, 2'b01, 16'h0001, 0, 16'h0000);
        add_vec(0, 4'd10, 2'b00, 16'h0000, 0, 16'h0002);
        add_vec(1, 4'd10, 2'b11, 16'hFFFF, 0, 16'h0000);
        add_vec(0, 4'd10, 2'b00, 16'h0000, 0, 16'h0002);
        for (int i = 0; i < vecs.size(); i++) begin
            bus_xfer(vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].dat,
                     vecs[i].exp_err, vecs[i].exp_dat, 1'b0);
        end

        // Random accesses above the control word must all error out.
        repeat (4) begin
            a = $urandom_range(11, 15);
            bus_xfer(1'($urandom_range(0, 1)), 4'(a), 2'b11, 16'($urandom_range(0, 65535)),
                     1, 16'h0000, 1'b0);
        end

        // Bus writes alone leave the active set untouched.
        chk("pre_commit_pending", commit_pending_o, 1);
        check_coef("pre_commit");

        // Committing tick.
        upd0 = upd_cnt;
        tick_pulse();
        chk("commit_upd_pulse", coef_upd_o, 1);
        exp_act[2] = 16'hABCD;
        exp_act[6] = 16'h1234;
        check_coef("commit");
        chk("commit_pending_clr", commit_pending_o, 0);
        @(negedge clk_i);
        chk("commit_upd_drop", coef_upd_o, 0);
        chk("commit_upd_cnt", 32'(upd_cnt - upd0), 1);
        bus_xfer(0, 4'd10, 2'b00, 16'h0, 0, 16'h0000, 1'b0);

        // Tick with nothing armed.
        upd0 = upd_cnt;
        tick_pulse();
        @(negedge clk_i);
        chk("clean_tick_upd", 32'(upd_cnt - upd0), 0);
        check_coef("clean_tick");

        // Commit request on the same cycle as a tick: copy waits for the next tick.
        bus_xfer(1, 4'd0, 2'b11, 16'h5555, 0, 16'h0000, 1'b0);
        upd0 = upd_cnt;
        bus_xfer(1, 4'd10, 2'b01, 16'h0001, 0, 16'h0000, 1'b1);
        chk("same_tick_pending", commit_pending_o, 1);
        chk("same_tick_upd", 32'(upd_cnt - upd0), 0);
        check_coef("same_tick");
        tick_pulse();
        @(negedge clk_i);
        exp_act[0] = 16'h5555;
        chk("next_tick_upd", 32'(upd_cnt - upd0), 1);
        check_coef("next_tick");

        // Shadow write on a committing tick: active gets the old shadow value.
        bus_xfer(1, 4'd1, 2'b11, 16'h1111, 0, 16'h0000, 1'b0);
        bus_xfer(1, 4'd10, 2'b01, 16'h0001, 0, 16'h0000, 1'b0);
        bus_xfer(1, 4'd1, 2'b11, 16'h2222, 0, 16'h0000, 1'b1);
        exp_act[1] = 16'h1111;
        check_coef("wr_on_tick");
        chk("wr_on_tick_pending", commit_pending_o, 0);
        bus_xfer(0, 4'd1, 2'b00, 16'h0, 0, 16'h2222, 1'b0);

        // Reset while a response is on the bus.
        bus_xfer(1, 4'd10, 2'b01, 16'h0001, 0, 16'h0000, 1'b0);
        chk("pre_rst_pending", commit_pending_o, 1);
        @(negedge clk_i);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 4'd6; sel_i = 2'b00;
        @(posedge clk_i);
        #1;
        chk("mid_rst_ack_before", ack_o, 1);
        rst_i = 1'b1;
        #1;
        chk("mid_rst_ack_drop", ack_o, 0);
        chk("mid_rst_dat", dat_o, 0);
        chk("mid_rst_state", bus_state_o, 0);
        chk("mid_rst_pending", commit_pending_o, 0);
        cyc_i = 1'b0; stb_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        reset_model();
        check_coef("after_rst");
        chk("after_rst_upd", coef_upd_o, 0);
        bus_xfer(0, 4'd6, 2'b00, 16'h0, 0, 16'h001F, 1'b0);
        bus_xfer(0, 4'd0, 2'b00, 16'h0, 0, 16'h00FF, 1'b0);
        bus_xfer(0, 4'd10, 2'b00, 16'h0, 0, 16'h0000, 1'b0);

        repeat (2) @(negedge clk_i);
        chk("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Safety net against a stalled run.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
